// File: rtl/mul_div_unit.sv
// Iterative radix-2 signed multiply/divide unit. One operand bit is handled per cycle.
// The 64-bit result is held in HI/LO for the MFHI/MFLO path.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             iClk,
    input  logic             nRst,
    input  logic             iStart,
    input  logic             iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo,
    output logic             oBusy,
    output logic             oDone,
    output logic             oDivZero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam int CW = $clog2(WIDTH + 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               op;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   in_mag_a;
    logic [WIDTH-1:0]   in_mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   orig_a;

    // Magnitudes are unsigned, so |most-negative| fits without overflow.
    assign in_mag_a = iA[WIDTH-1] ? ('0 - iA) : iA;
    assign in_mag_b = iB[WIDTH-1] ? ('0 - iB) : iB;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

        // Shifted remainder needs WIDTH+1 bits; the MSB of the difference is the borrow.
        div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
        div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

        prod_fix = (sign_a ^ sign_b) ? ('0 - acc) : acc;
        quot_fix = (sign_a ^ sign_b) ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = sign_a ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        orig_a   = sign_a ? ('0 - mag_a) : mag_a;
    end

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op       <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            oHi      <= '0;
            oLo      <= '0;
            oDivZero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (iStart) begin
                        op       <= iOp;
                        sign_a   <= iA[WIDTH-1];
                        sign_b   <= iB[WIDTH-1];
                        mag_a    <= in_mag_a;
                        mag_b    <= in_mag_b;
                        // Low half holds the multiplier (MUL) or the dividend (DIV).
                        acc      <= {{WIDTH{1'b0}}, (iOp ? in_mag_a : in_mag_b)};
                        cnt      <= '0;
                        oDivZero <= 1'b0;
                        state    <= S_CALC;
                    end else if (state == S_DONE) begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc <= op ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!op) begin
                        oHi <= prod_fix[2*WIDTH-1:WIDTH];
                        oLo <= prod_fix[WIDTH-1:0];
                    end else if (mag_b == '0) begin
                        oHi      <= orig_a;
                        oLo      <= '1;
                        oDivZero <= 1'b1;
                    end else begin
                        oHi <= rem_fix;
                        oLo <= quot_fix;
                    end
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign oBusy = (state == S_CALC) || (state == S_FIX);
    assign oDone = (state == S_DONE);

endmodule
